bcp_clause_scheduler: RTL and testbench
=======================================

# bcp_clause_scheduler

Pending-clause queue directly upstream of the BCP clause-index one-hot decoder. Watch-list logic pushes indices of clauses that need re-evaluation after an assignment. The block buffers them in a FIFO and issues one index at a time on `de_in`. It holds each index stable until the clause evaluator reports completion, and discards all pending work on a conflict flush.

## Interface
Parameters:
- `DEPTH`, default 8: FIFO entries; power of two, ≥ 2.
- Index width is `` `clause_num_log ``; clause count is `` `clause_num `` (= 1 << `` `clause_num_log ``). Both are the existing global macros.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `push_valid` in 1: a clause index is offered this cycle.
- `push_idx` in `` `clause_num_log ``: clause index offered.
- `push_ready` out 1: `!full`; combinational from state only.
- `flush` in 1: conflict/backtrack; discard all pending and in-flight work.
- `eval_done` in 1: evaluator finished the clause on `de_in`.
- `de_in` out `` `clause_num_log ``: registered index driven to the decoder.
- `issue_valid` out 1: `de_in` holds a clause under evaluation.
- `busy` out 1: `issue_valid | !empty`.
- `count` out `$clog2(DEPTH+1)`: FIFO occupancy; excludes the in-flight entry.
- `overflow` out 1: sticky; a push was offered while full.

## Operation
- FIFO: circular buffer, `DEPTH` entries, write/read pointers with an extra wrap bit. Full is `count == DEPTH`; empty is `count == 0`.
- Push accept: `push_valid & push_ready & !flush` enqueues `push_idx`.
- Push while full: entry dropped, `overflow` set, FIFO unchanged. This applies even if a pop occurs on the same edge.
- FSM states:
  - IDLE → EVAL: when FIFO is non-empty. Pop head into `de_in`; `issue_valid` ← 1.
  - EVAL → EVAL: `eval_done` with FIFO non-empty. Pop the next head into `de_in` back-to-back; `issue_valid` stays 1.
  - EVAL → IDLE: `eval_done` with FIFO empty. `issue_valid` ← 0; `de_in` holds its last value.
  - `eval_done` in IDLE: ignored.
- Same-edge push and pop with FIFO neither full nor empty: both happen; `count` is unchanged.
- Push to an empty FIFO is never popped on the same edge; the pop uses pre-edge occupancy.
- `flush` has highest priority. At the edge:
  - pointers cleared, `count` 0, state IDLE, `issue_valid` 0;
  - any same-edge push is dropped and not flagged;
  - `eval_done` is ignored;
  - `overflow` is cleared;
  - `de_in` holds its value.
- `rst` has the same effect as `flush`, asynchronously, and also zeroes `de_in`.

## Timing
- Reset values: `de_in` 0, `issue_valid` 0, `busy` 0, `count` 0, `overflow` 0, `push_ready` 1.
- Latency to issue: push accepted at edge E into an empty, idle block gives `issue_valid` = 1 and `de_in` = the pushed index after edge E+1. There is no bypass path.
- Throughput: one issue per `eval_done`. An evaluator asserting `eval_done` every cycle drains one entry per cycle.
- `de_in` is stable for every cycle `issue_valid` is high until the edge that samples `eval_done`.
- `push_ready` and `busy` are combinational from registered state only; `count` and `overflow` are registered.

## Configuration
- `BCP_SCHED_DEDUP_EN`: compiles in duplicate suppression.
- Defined:
  - A `` `clause_num ``-bit pending bitmap tracks indices currently in the FIFO. The bit is set on enqueue and cleared on pop.
  - A push whose index is already pending is accepted (handshake completes) but not enqueued; `count` is unchanged and `overflow` is not set.
  - An index popped on the same edge counts as not pending and is enqueued.
  - The index currently on `de_in` is not pending, so it can be re-queued.
  - `flush`/`rst` clear the bitmap.
- Undefined: no bitmap; every accepted push is enqueued.

## Test plan
- Reset, then push 5 at edge 1, `eval_done` never → `issue_valid` = 1 and `de_in` = 5 after edge 2; `count` = 0; `de_in` holds 5 indefinitely.
- Push 1,2,3 on consecutive cycles, `eval_done` held high → `de_in` = 1,2,3 on consecutive cycles, then IDLE with `busy` = 0.
- With `eval_done` low, push `DEPTH`+2 entries (the first is issued) → `count` = `DEPTH`, `push_ready` = 0, `overflow` = 1; the last entry is lost.
- Fill 3 entries, assert `flush` together with a push of 7 → next cycle `count` = 0, `issue_valid` = 0, `overflow` = 0; 7 never issued.
- `BCP_SCHED_DEDUP_EN`: push 4,4,6,4 while 4 is pending → `count` = 2, issue order 4,6. Push 4 again while it is on `de_in` → enqueued, `count` +1.
- Assert `rst` mid-EVAL, between clock edges → all outputs immediately at reset values; first push after release issues at the second edge.

Source files
------------

// File: rtl/bcp_clause_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : bcp_clause_scheduler
// Brief    : Pending-clause FIFO feeding the clause-index decoder, one issue per
//            eval_done. Optional macro BCP_SCHED_DEDUP_EN adds duplicate suppression.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef CLAUSE_NUM_LOG
`define CLAUSE_NUM_LOG 5
`endif
`ifndef CLAUSE_NUM
`define CLAUSE_NUM (1 << `CLAUSE_NUM_LOG)
`endif

module bcp_clause_scheduler #(
    parameter int DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push_valid,
    input  logic [`CLAUSE_NUM_LOG-1:0]    push_idx,
    output logic                          push_ready,
    input  logic                          flush,
    input  logic                          eval_done,
    output logic [`CLAUSE_NUM_LOG-1:0]    de_in,
    output logic                          issue_valid,
    output logic                          busy,
    output logic [$clog2(DEPTH+1)-1:0]    count,
    output logic                          overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int IW = `CLAUSE_NUM_LOG;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EVAL = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [IW-1:0]     r_mem [DEPTH];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_overflow;
    logic [IW-1:0]     r_de_in;

    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_push_hs;
    logic              w_dup;
    logic              w_enq;
    logic [IW-1:0]     w_head;

    // Wrap bit distinguishes full from empty when the index bits match.
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_head    = r_mem[r_rd_ptr[AW-1:0]];
    assign w_push_hs = push_valid && !w_full && !flush;
    assign w_enq     = w_push_hs && !w_dup;

    assign push_ready  = !w_full;
    assign issue_valid = (r_state == ST_EVAL);
    assign busy        = issue_valid || !w_empty;
    assign count       = r_count;
    assign overflow    = r_overflow;
    assign de_in       = r_de_in;

`ifdef BCP_SCHED_DEDUP_EN
    logic [`CLAUSE_NUM-1:0] r_pending;

    // An index leaving the FIFO on this edge is no longer pending.
    assign w_dup = r_pending[push_idx] && !(w_pop && (w_head == push_idx));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
        end else if (flush) begin
            r_pending <= '0;
        end else begin
            if (w_pop) begin
                r_pending[w_head] <= 1'b0;
            end
            if (w_enq) begin
                r_pending[push_idx] <= 1'b1;
            end
        end
    end
`else
    assign w_dup = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        if (flush) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_state_next = ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    if (eval_done) begin
                        if (!w_empty) begin
                            w_pop = 1'b1;
                        end else begin
                            w_state_next = ST_IDLE;
                        end
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem[r_wr_ptr[AW-1:0]] <= push_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_de_in    <= '0;
        end else if (flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_de_in  <= w_head;
            end
            case ({w_enq, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (push_valid && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bcp_clause_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcp_clause_scheduler
// Brief    : Directed self-checking bench for bcp_clause_scheduler.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef CLAUSE_NUM_LOG
`define CLAUSE_NUM_LOG 5
`endif

module tb_bcp_clause_scheduler;

    localparam int DEPTH = 8;
    localparam int IW    = `CLAUSE_NUM_LOG;
    localparam int CW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          rst;
    logic          push_valid;
    logic [IW-1:0] push_idx;
    logic          push_ready;
    logic          flush;
    logic          eval_done;
    logic [IW-1:0] de_in;
    logic          issue_valid;
    logic          busy;
    logic [CW-1:0] count;
    logic          overflow;

    int n_checks = 0;
    int n_fail   = 0;

    bcp_clause_scheduler #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .push_valid  (push_valid),
        .push_idx    (push_idx),
        .push_ready  (push_ready),
        .flush       (flush),
        .eval_done   (eval_done),
        .de_in       (de_in),
        .issue_valid (issue_valid),
        .busy        (busy),
        .count       (count),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_de_in"},    32'(de_in),       0);
        chk({tag, "_iv"},       32'(issue_valid), 0);
        chk({tag, "_busy"},     32'(busy),        0);
        chk({tag, "_count"},    32'(count),       0);
        chk({tag, "_overflow"}, 32'(overflow),    0);
        chk({tag, "_ready"},    32'(push_ready),  1);
    endtask

    task automatic push(input int idx);
        push_valid = 1'b1;
        push_idx   = IW'(idx);
        tick();
        push_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        push_valid = 1'b0;
        push_idx   = '0;
        flush      = 1'b0;
        eval_done  = 1'b0;
        tick();
        tick();
        chk_reset_vals("rst");
        rst = 1'b0;

        // Single push, no eval_done: one-cycle queue latency then held forever.
        push(5);
        chk("lat_iv_e1",    32'(issue_valid), 0);
        chk("lat_count_e1", 32'(count),       1);
        tick();
        chk("lat_iv_e2",    32'(issue_valid), 1);
        chk("lat_de_e2",    32'(de_in),       5);
        chk("lat_count_e2", 32'(count),       0);
        chk("lat_busy_e2",  32'(busy),        1);
        repeat (3) tick();
        chk("lat_hold_de",  32'(de_in),       5);
        chk("lat_hold_iv",  32'(issue_valid), 1);
        eval_done = 1'b1;
        tick();
        eval_done = 1'b0;
        chk("lat_end_iv",   32'(issue_valid), 0);
        chk("lat_end_de",   32'(de_in),       5);
        chk("lat_end_busy", 32'(busy),        0);

        // Back-to-back issue with eval_done held high.
        eval_done = 1'b1;
        push(1);
        chk("b2b_count_a", 32'(count),       1);
        chk("b2b_iv_a",    32'(issue_valid), 0);
        push(2);
        chk("b2b_de_b",    32'(de_in),       1);
        chk("b2b_iv_b",    32'(issue_valid), 1);
        chk("b2b_count_b", 32'(count),       1);
        push(3);
        chk("b2b_de_c",    32'(de_in),       2);
        chk("b2b_count_c", 32'(count),       1);
        tick();
        chk("b2b_de_d",    32'(de_in),       3);
        chk("b2b_count_d", 32'(count),       0);
        tick();
        chk("b2b_iv_e",    32'(issue_valid), 0);
        chk("b2b_busy_e",  32'(busy),        0);
        chk("b2b_de_e",    32'(de_in),       3);
        eval_done = 1'b0;

        // Overflow: DEPTH+2 pushes, first is issued, last is dropped.
        for (int i = 0; i < DEPTH + 2; i++) begin
            push(10 + i);
        end
        chk("ovf_count", 32'(count),      DEPTH);
        chk("ovf_ready", 32'(push_ready), 0);
        chk("ovf_flag",  32'(overflow),   1);
        chk("ovf_de",    32'(de_in),      10);
        // Push while full with a same-edge pop is still dropped.
        eval_done  = 1'b1;
        push(30);
        chk("ovf_pop_count", 32'(count), DEPTH - 1);
        chk("ovf_pop_de",    32'(de_in), 11);
        for (int i = 1; i < DEPTH; i++) begin
            tick();
            chk("ovf_drain_de", 32'(de_in), 11 + i);
        end
        chk("ovf_drain_count", 32'(count), 0);
        tick();
        chk("ovf_drain_iv",  32'(issue_valid), 0);
        chk("ovf_drain_last", 32'(de_in),      18);
        chk("ovf_sticky",    32'(overflow),    1);
        eval_done = 1'b0;

        // Flush with a same-edge push and eval_done.
        push(1);
        push(2);
        push(3);
        push(4);
        chk("fl_pre_count", 32'(count), 3);
        flush      = 1'b1;
        eval_done  = 1'b1;
        push(7);
        flush      = 1'b0;
        eval_done  = 1'b0;
        chk("fl_count", 32'(count),       0);
        chk("fl_iv",    32'(issue_valid), 0);
        chk("fl_ovf",   32'(overflow),    0);
        chk("fl_de",    32'(de_in),       1);
        chk("fl_busy",  32'(busy),        0);
        chk("fl_ready", 32'(push_ready),  1);
        tick();
        tick();
        chk("fl_no7_iv", 32'(issue_valid), 0);
        chk("fl_no7_de", 32'(de_in),       1);

`ifdef BCP_SCHED_DEDUP_EN
        // Duplicate suppression: 9 in flight, then 4,4,6,4.
        push(9);
        push(4);
        chk("dd_de9",    32'(de_in), 9);
        push(4);
        push(6);
        push(4);
        chk("dd_count",  32'(count),    2);
        chk("dd_ovf",    32'(overflow), 0);
        eval_done = 1'b1;
        tick();
        eval_done = 1'b0;
        chk("dd_de4",    32'(de_in), 4);
        chk("dd_count1", 32'(count), 1);
        push(4);
        chk("dd_requeue_count", 32'(count), 2);
        eval_done = 1'b1;
        tick();
        chk("dd_de6",    32'(de_in), 6);
        tick();
        chk("dd_de4b",   32'(de_in), 4);
        tick();
        chk("dd_idle",   32'(issue_valid), 0);
        eval_done = 1'b0;
`endif

        // Asynchronous reset between edges while evaluating.
        push(21);
        push(22);
        push(23);
        chk("ar_pre_iv",    32'(issue_valid), 1);
        chk("ar_pre_count", 32'(count),       2);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("arst");
        #1;
        rst = 1'b0;
        push(25);
        chk("ar_post_iv_e1", 32'(issue_valid), 0);
        tick();
        chk("ar_post_iv_e2", 32'(issue_valid), 1);
        chk("ar_post_de_e2", 32'(de_in),       25);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
